fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Consumes the combinational control decoder's Jump/BranchEn/PCTarg/Ack outputs plus the ALU branch flag, and produces the program counter that addresses instruction ROM.
- Owns the program start handshake, redirects the PC through a small 4-entry target table, and raises Done when the program halts.
- Sits between the control decoder/ALU and instruction ROM; it is the only clocked state in the fetch path.

Parameters:
- PC_W, 10, program counter width; ROM depth is 2**PC_W.
- START_ADDR, 0, PC value on reset and while Start is held.
- TGT0..TGT3, 0/0/0/0, PC_W-bit table entries selected by PCTarg.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level request from the testbench; high = hold at START_ADDR; falling edge launches the program.
- Jump  in  1  unconditional redirect request from the control decoder.
- BranchEn  in  1  conditional redirect request from the control decoder.
- Taken  in  1  ALU condition flag; qualifies BranchEn.
- PCTarg  in  2  target-table index from the control decoder.
- Ack  in  1  halt instruction decoded (all-ones opcode).
- ProgCtr  out  PC_W  instruction ROM address.
- Running  out  1  high in RUN state.
- Done  out  1  sticky program-complete flag.

Behaviour:
- States: IDLE, ARM, RUN, HALT.
- Reset (synchronous, active-high): state=IDLE, ProgCtr=START_ADDR, Running=0, Done=0. Reset overrides every other input in the same cycle, including mid-RUN.
- IDLE: ProgCtr=START_ADDR. Start=1 moves to ARM.
- ARM: ProgCtr is held at START_ADDR while Start=1. Start=0 moves to RUN; the first instruction fetched is at START_ADDR.
- RUN (Running=1): next-PC priority, evaluated once per cycle:
  1. Start=1: go to ARM, PC=START_ADDR.
  2. Ack=1: go to HALT, PC frozen, Done<=1 on the next edge.
  3. Jump=1: PC<=TGT[PCTarg] (absolute target).
  4. BranchEn & Taken: PC<=PC+TGT[PCTarg], signed offset in PC_W-bit two's complement.
  5. Otherwise: PC<=PC+1.
- HALT: PC and Done are held. Jump/BranchEn/Ack are ignored. Start=1 clears Done and moves to ARM.
- Arithmetic: all PC math is modulo 2**PC_W. Increment from all-ones wraps to 0. Branch offsets wrap the same way; no overflow flag.
- BranchEn with Taken=0 behaves as a plain increment.
- Simultaneous Jump and BranchEn: Jump wins.
- Latency: redirects take effect on the next edge. ProgCtr is registered; there is no combinational path from inputs to ProgCtr.
- Running and Done are registered outputs and never both 1.

Optional Feature:
- Macro: FETCH_CYCLE_CNT_EN.
- Defined: adds output CycleCnt [15:0].
  - Cleared on Reset and on entry to ARM.
  - Increments every cycle in RUN and saturates at 16'hFFFF.
  - Held in HALT so the bench reads the program's cycle count.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package definitions (alongside the existing opcode constants):
  - fetch_state_t enum {IDLE, ARM, RUN, HALT}.
  - Constant kPC_W.
  - Default target-table constants.
- Sub-module fetch_target_lut: combinational PCTarg -> PC_W-bit value, parameterised by TGT0..TGT3, instantiated once.
- FSM and PC register stay in fetch_sequencer.

Test Plan (all with PC_W=10):
- Start/launch: Reset, Start=1 for 3 cycles, then Start=0 -> ProgCtr=0 during ARM; sequence 0,1,2,3 with Running=1 from the first RUN cycle.
- Jump: TGT2=10'd100, Jump=1, PCTarg=2 at PC=5 -> next ProgCtr=100, then 101.
- Branch taken/not taken: TGT1=10'h3FE (-2), BranchEn=1, PCTarg=1 at PC=20.
  - Taken=1 -> next ProgCtr=18.
  - Repeat with Taken=0 -> next ProgCtr=21.
- Wrap and priority:
  - PC=1023, no redirect -> next ProgCtr=0.
  - Jump and BranchEn&Taken together, TGT0=7, PCTarg=0 -> next ProgCtr=7.
- Halt: Ack=1 at PC=42 -> ProgCtr stays 42, Done=1 next cycle, Running=0. Later Jump=1 is ignored. Start=1 clears Done and sets ProgCtr=0.
- Reset mid-run: Reset=1 at PC=300 in RUN -> next edge gives IDLE, ProgCtr=0, Done=0, Running=0. With FETCH_CYCLE_CNT_EN defined, CycleCnt=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-path definitions: opcode constants, sequencer states, PC width
// and default target-table contents.
package fetch_sequencer_pkg;

    localparam int kOPCODE_W = 3;
    localparam logic [kOPCODE_W-1:0] kOP_HALT = '1;

    localparam int kPC_W = 10;

    localparam int kTGT0 = 0;
    localparam int kTGT1 = 0;
    localparam int kTGT2 = 0;
    localparam int kTGT3 = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_target_lut.sv
// Combinational 4-entry redirect table: PCTarg index -> absolute target or
// signed branch offset, depending on how the sequencer uses it.
module fetch_target_lut
    import fetch_sequencer_pkg::*;
#(
    parameter int              PC_W = kPC_W,
    parameter logic [PC_W-1:0] TGT0 = PC_W'(kTGT0),
    parameter logic [PC_W-1:0] TGT1 = PC_W'(kTGT1),
    parameter logic [PC_W-1:0] TGT2 = PC_W'(kTGT2),
    parameter logic [PC_W-1:0] TGT3 = PC_W'(kTGT3)
) (
    input  logic [1:0]      pc_targ,
    output logic [PC_W-1:0] target
);

    always_comb begin
        target = TGT0;
        case (pc_targ)
            2'd0: target = TGT0;
            2'd1: target = TGT1;
            2'd2: target = TGT2;
            2'd3: target = TGT3;
            default: target = TGT0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter sequencer: start handshake, jump/branch redirects, halt.
// Optional FETCH_CYCLE_CNT_EN adds a saturating RUN-cycle counter on CycleCnt.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              PC_W       = kPC_W,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [PC_W-1:0] TGT0       = PC_W'(kTGT0),
    parameter logic [PC_W-1:0] TGT1       = PC_W'(kTGT1),
    parameter logic [PC_W-1:0] TGT2       = PC_W'(kTGT2),
    parameter logic [PC_W-1:0] TGT3       = PC_W'(kTGT3)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Jump,
    input  logic            BranchEn,
    input  logic            Taken,
    input  logic [1:0]      PCTarg,
    input  logic            Ack,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [15:0]     CycleCnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] target;

    fetch_target_lut #(
        .PC_W (PC_W),
        .TGT0 (TGT0),
        .TGT1 (TGT1),
        .TGT2 (TGT2),
        .TGT3 (TGT3)
    ) u_target_lut (
        .pc_targ (PCTarg),
        .target  (target)
    );

    // Next-state and next-PC; in RUN the branches below encode redirect priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                pc_d = START_ADDR;
                if (Start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                pc_d = START_ADDR;
                if (!Start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    state_d = ARM;
                    pc_d    = START_ADDR;
                end else if (Ack) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (Jump) begin
                    pc_d = target;
                end else if (BranchEn && Taken) begin
                    pc_d = pc_q + target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            HALT: begin
                if (Start) begin
                    state_d = ARM;
                    pc_d    = START_ADDR;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_ADDR;
                done_d  = 1'b0;
            end
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= START_ADDR;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    // Cleared on every entry to ARM so each launch counts from zero; held in HALT.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_d == ARM && state_q != ARM) begin
            cycle_cnt_d = '0;
        end else if (state_q == RUN && cycle_cnt_q != 16'hFFFF) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign CycleCnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: launch, jump, branch, wrap, priority,
// halt, restart and mid-run reset with PC_W=10.
module tb_fetch_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Jump;
    logic       BranchEn;
    logic       Taken;
    logic [1:0] PCTarg;
    logic       Ack;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] CycleCnt;
`endif

    typedef struct {
        logic [9:0] pc;
        logic       running;
        logic       done;
        string      tag;
    } exp_t;

    exp_t expQueue[$];
    int   checkCount = 0;
    int   errorCount = 0;
    logic [9:0] curPc;

    fetch_sequencer #(
        .PC_W       (10),
        .START_ADDR (10'd0),
        .TGT0       (10'd7),
        .TGT1       (10'h3FE),
        .TGT2       (10'd100),
        .TGT3       (10'h3FF)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Jump     (Jump),
        .BranchEn (BranchEn),
        .Taken    (Taken),
        .PCTarg   (PCTarg),
        .Ack      (Ack),
        .ProgCtr  (ProgCtr),
        .Running  (Running),
        .Done     (Done)
`ifdef FETCH_CYCLE_CNT_EN
        ,
        .CycleCnt (CycleCnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, queue what the edge must produce, then compare.
    task automatic applyStimulus(input logic rst, input logic st, input logic jmp,
                                 input logic br, input logic tk, input logic [1:0] tg,
                                 input logic ak, input logic [9:0] ePc,
                                 input logic eRun, input logic eDone, input string tag);
        exp_t e;
        exp_t got;
        @(negedge Clk);
        Reset    = rst;
        Start    = st;
        Jump     = jmp;
        BranchEn = br;
        Taken    = tk;
        PCTarg   = tg;
        Ack      = ak;
        e.pc      = ePc;
        e.running = eRun;
        e.done    = eDone;
        e.tag     = tag;
        expQueue.push_back(e);
        @(posedge Clk);
        #1;
        got = expQueue.pop_front();
        checkOutput({got.tag, ".pc"},   int'(ProgCtr), int'(got.pc));
        checkOutput({got.tag, ".run"},  int'(Running), int'(got.running));
        checkOutput({got.tag, ".done"}, int'(Done),    int'(got.done));
    endtask

    task automatic idleCycle(input logic [9:0] ePc, input logic eRun, input logic eDone,
                             input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, ePc, eRun, eDone, tag);
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0, "reset");
    endtask

    task automatic launchProgram();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0, "arm");
        idleCycle(10'd0, 1'b1, 1'b0, "launch");
        curPc = 10'd0;
    endtask

    task automatic runTo(input logic [9:0] target);
        while (curPc != target) begin
            curPc = curPc + 10'd1;
            idleCycle(curPc, 1'b1, 1'b0, "step");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b0; Start = 1'b0; Jump = 1'b0; BranchEn = 1'b0;
        Taken = 1'b0; PCTarg = 2'd0; Ack = 1'b0;

        resetDut();
        idleCycle(10'd0, 1'b0, 1'b0, "idle");
        launchProgram();
        runTo(10'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 10'd100, 1'b1, 1'b0, "jump");
        idleCycle(10'd101, 1'b1, 1'b0, "postjump");

        resetDut();
        launchProgram();
        runTo(10'd20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 10'd18, 1'b1, 1'b0, "brtaken");
        curPc = 10'd18;
        runTo(10'd20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 10'd21, 1'b1, 1'b0, "brnottaken");

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 10'd1023, 1'b1, 1'b0, "jumpmax");
        idleCycle(10'd0, 1'b1, 1'b0, "wrap");
        idleCycle(10'd1, 1'b1, 1'b0, "postwrap");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 10'd7, 1'b1, 1'b0, "jumpwins");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 10'd5, 1'b1, 1'b0, "brback");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 10'd0, 1'b0, 1'b0, "startinrun");

        resetDut();
        launchProgram();
        runTo(10'd42);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 10'd42, 1'b0, 1'b1, "halt");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 10'd42, 1'b0, 1'b1, "haltignore");
`ifdef FETCH_CYCLE_CNT_EN
        checkOutput("cyclecnt.halt", int'(CycleCnt), 43);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0, "restart");
`ifdef FETCH_CYCLE_CNT_EN
        checkOutput("cyclecnt.arm", int'(CycleCnt), 0);
`endif
        idleCycle(10'd0, 1'b1, 1'b0, "relaunch");
        curPc = 10'd0;
        runTo(10'd300);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 10'd0, 1'b0, 1'b0, "midreset");
`ifdef FETCH_CYCLE_CNT_EN
        checkOutput("cyclecnt.reset", int'(CycleCnt), 0);
`endif
        idleCycle(10'd0, 1'b0, 1'b0, "postreset");

        $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
